// File: rtl/md_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [MD_WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign helpers: operand magnitudes at entry, conditional
// negation of product / quotient / remainder at the end of an operation.
module md_sign_fix #(
    parameter int WIDTH = md_pkg::MD_WIDTH
) (
    input  logic                 sign,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    input  logic [2*WIDTH-1:0]   prod,
    input  logic                 prod_neg,
    output logic [2*WIDTH-1:0]   prod_fixed,
    input  logic [WIDTH-1:0]     quo,
    input  logic                 quo_neg,
    output logic [WIDTH-1:0]     quo_fixed,
    input  logic [WIDTH-1:0]     rem,
    input  logic                 rem_neg,
    output logic [WIDTH-1:0]     rem_fixed
);

    // The magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    assign a_mag      = (sign && a[WIDTH-1]) ? -a : a;
    assign b_mag      = (sign && b[WIDTH-1]) ? -b : b;

    assign prod_fixed = prod_neg ? -prod : prod;
    assign quo_fixed  = quo_neg  ? -quo  : quo;
    assign rem_fixed  = rem_neg  ? -rem  : rem;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide, one bit per cycle, with a start/busy/done handshake.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Div,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 op_div, neg_q, neg_r, b_zero;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q;

    logic [WIDTH-1:0]     a_mag, b_mag, quo_fixed, rem_fixed;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic                 div_borrow;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .sign       (Sign),
        .a          (A),
        .b          (B),
        .a_mag      (a_mag),
        .b_mag      (b_mag),
        .prod       (acc),
        .prod_neg   (neg_q),
        .prod_fixed (prod_fixed),
        .quo        (acc[WIDTH-1:0]),
        .quo_neg    (neg_q),
        .quo_fixed  (quo_fixed),
        .rem        (rem),
        .rem_neg    (neg_r),
        .rem_fixed  (rem_fixed)
    );

    // Multiply keeps the multiplier in acc[W-1:0] and the running product in
    // the upper half; divide shifts the dividend out of acc[W-1:0] while
    // quotient bits shift in. opnd is the multiplicand or divisor magnitude.
    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        div_shift  = {rem, acc[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opnd};
        div_borrow = div_diff[WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt is assigned before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = done_q;
        HI   = hi_q;
        LO   = lo_q;
    end

    // NOTE: every register here uses <= so all updates see pre-edge values;
    // a blocking assignment would let later statements read the new value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            rem    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (start) begin
                        op_div <= Div;
                        neg_q  <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r  <= Sign & A[WIDTH-1];
                        b_zero <= (B == '0);
                        opnd   <= Div ? b_mag : a_mag;
                        acc    <= {{WIDTH{1'b0}}, (Div ? a_mag : b_mag)};
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (op_div) begin
                        rem             <= div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], ~div_borrow};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (op_div) begin
                        // With a zero divisor the remainder path reproduces A.
                        lo_q <= b_zero ? DIV0_LO : quo_fixed;
                        hi_q <= rem_fixed;
                    end else begin
                        hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: arithmetic results, latency,
// handshake, HI/LO write strobes and asynchronous reset.
module tb_md_unit;

    localparam int W = 32;

    logic         clk, reset, start, Div, Sign, hi_we, lo_we;
    logic [W-1:0] A, B, wdata;
    logic         busy, done;
    logic [W-1:0] HI, LO;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc;
    int pulses;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .Div   (Div),
        .Sign  (Sign),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the edge that sampled start.
    task automatic launch(input logic div, input logic sign, input logic [W-1:0] a, input logic [W-1:0] b);
        Div   = div;
        Sign  = sign;
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic div, input logic sign,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int c;
        launch(div, sign, a, b);
        check({tag, "_busy"}, W'(busy), 32'd1);
        wait_done(c);
        check({tag, "_latency"}, W'(c), 32'd33);
        check({tag, "_idle"}, W'(busy), 32'd0);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; Div = 1'b0; Sign = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; A = '0; B = '0; wdata = '0;

        #2;
        check("rst_hi",   HI, 32'h0);
        check("rst_lo",   LO, 32'h0);
        check("rst_busy", W'(busy), 32'd0);
        check("rst_done", W'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        check("done_single_pulse", W'(done), 32'd0);

        run_op("mult_neg", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIVU 7/2 with an ignored restart at E5 and an ignored MTHI at E6.
        launch(1'b1, 1'b0, 32'd7, 32'd2);
        repeat (4) @(negedge clk);
        Div = 1'b0; A = 32'd100; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", W'(busy), 32'd1);
        wdata = 32'h1234; hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        check("hi_we_busy", HI, 32'hFFFF_FFFF);
        wait_done(cyc);
        check("divu_latency", W'(cyc), 32'd27);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        run_op("div_ovf",   1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_zero", 1'b1, 1'b0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op("div_zero",  1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF);

        @(negedge clk);
        wdata = 32'h1234; hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", HI, 32'h1234);
        check("mthi_lo", LO, 32'hFFFF_FFFF);

        wdata = 32'hABCD; hi_we = 1'b1; lo_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthilo_hi", HI, 32'hABCD);
        check("mthilo_lo", LO, 32'hABCD);

        // MTLO coinciding with start: write lands at E0, result lands at E33.
        wdata = 32'h5555; lo_we = 1'b1;
        launch(1'b0, 1'b0, 32'd6, 32'd7);
        lo_we = 1'b0;
        check("start_mtlo_lo", LO, 32'h5555);
        check("start_mtlo_hi", HI, 32'hABCD);
        check("start_mtlo_busy", W'(busy), 32'd1);
        wait_done(cyc);
        check("start_mtlo_latency", W'(cyc), 32'd33);
        check("start_mtlo_res_lo", LO, 32'd42);
        check("start_mtlo_res_hi", HI, 32'd0);

        // Asynchronous reset at E10 of a DIV.
        launch(1'b1, 1'b1, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_hi",   HI, 32'h0);
        check("abort_lo",   LO, 32'h0);
        check("abort_busy", W'(busy), 32'd0);
        check("abort_done", W'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", W'(pulses), 32'd0);

        run_op("multu_small", 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
